// File: rtl/fpm_pkg.sv
// Shared definitions for the FP multiplier batch sequencer slice.
//   FP_W             IEEE-754 single-precision word width
//   NUM_VECTORS_DEF  default operand pairs per batch
//   MUL_LATENCY_DEF  default multiplier core latency in cycles
//   fpm_state_e      sequencer state encoding
package fpm_pkg;

  localparam int FP_W            = 32;
  localparam int NUM_VECTORS_DEF = 32;
  localparam int MUL_LATENCY_DEF = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    DRAIN     = 3'd2,
    WAIT_DONE = 3'd3,
    FINISH    = 3'd4
  } fpm_state_e;

endpackage

// File: rtl/fpm_batch_sequencer_if.sv
// Bundle between the sequencer, the operand/result stack and the multiplier core.
//   Stack side : a, b, done (from stack); start, we, we_ov, c, overflow (to stack)
//   Core side  : mul_a, mul_b, mul_in_valid (to core);
//                mul_result, mul_overflow, mul_out_valid (from core)
// master = sequencer view, slave = stack/core view.
interface fpm_batch_sequencer_if
  import fpm_pkg::*;
#(
  parameter int DATA_W = FP_W
) ();

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              done;
  logic              start;
  logic              we;
  logic              we_ov;
  logic [DATA_W-1:0] c;
  logic              overflow;

  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic              mul_in_valid;
  logic [DATA_W-1:0] mul_result;
  logic              mul_overflow;
  logic              mul_out_valid;

  modport master (
    input  a, b, done, mul_result, mul_overflow, mul_out_valid,
    output start, we, we_ov, c, overflow, mul_a, mul_b, mul_in_valid
  );

  modport slave (
    output a, b, done, mul_result, mul_overflow, mul_out_valid,
    input  start, we, we_ov, c, overflow, mul_a, mul_b, mul_in_valid
  );

endinterface

// File: rtl/fpm_valid_pipe.sv
// DEPTH-stage valid shift register modelling the multiplier core's fixed latency.
//   clk       system clock
//   reset     asynchronous active-low reset
//   in_valid  valid entering the core
//   out_valid in_valid delayed by DEPTH cycles
module fpm_valid_pipe
  import fpm_pkg::*;
#(
  parameter int DEPTH = MUL_LATENCY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] stage;

  // shift-and-or form keeps DEPTH=1 legal without a special case
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage <= '0;
    end else begin
      stage <= (stage << 1) | DEPTH'(in_valid);
    end
  end

  assign out_valid = stage[DEPTH-1];

endmodule

// File: rtl/fpm_batch_sequencer.sv
// Multiplier-side batch controller for the operand/result stack.
// Per go pulse it reads NUM_VECTORS operand pairs from the stack, forwards them
// to the multiplier core, writes each product/overflow back and pulses finished.
//   clk, reset      clock, asynchronous active-low reset
//   go              batch request, honoured only in IDLE
//   busy, finished  status: busy outside IDLE, finished pulse in FINISH
//   ov_count        results written with overflow=1 (FPM_SEQ_OV_COUNT_EN only)
//   bus             stack + core signals (fpm_batch_sequencer_if.master)
// Optional build macro: FPM_SEQ_OV_COUNT_EN adds the ov_count output and counter.
//
// state     | meaning
// IDLE      | waiting for go
// ISSUE     | start high, one operand pair read per cycle
// DRAIN     | all pairs issued, collecting remaining results
// WAIT_DONE | all results written, waiting for stack done
// FINISH    | one-cycle completion pulse
module fpm_batch_sequencer
  import fpm_pkg::*;
#(
  parameter  int NUM_VECTORS = NUM_VECTORS_DEF,
  parameter  int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter  int DATA_W      = FP_W,
  localparam int CNT_W       = $clog2(NUM_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic             busy,
  output logic             finished,
`ifdef FPM_SEQ_OV_COUNT_EN
  output logic [CNT_W-1:0] ov_count,
`endif
  fpm_batch_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_ISSUE     = ISSUE;
  localparam logic [2:0] S_DRAIN     = DRAIN;
  localparam logic [2:0] S_WAIT_DONE = WAIT_DONE;
  localparam logic [2:0] S_FINISH    = FINISH;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_VECTORS - 1);

  // The sequencer trusts mul_out_valid, so latency only matters as a sanity bound.
  if (MUL_LATENCY < 1) begin : g_latency_check
    $error("fpm_batch_sequencer: MUL_LATENCY must be at least 1");
  end

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  res_cnt;
  logic              done_seen;
  logic              in_valid_q;
  logic              we_q;
  logic [DATA_W-1:0] c_q;
  logic              ov_q;

  logic issuing;
  logic collecting;
  logic batch_start;
  logic accept;

  assign issuing     = (state == S_ISSUE);
  assign collecting  = (state == S_ISSUE) || (state == S_DRAIN) || (state == S_WAIT_DONE);
  assign batch_start = (state == S_IDLE) && go;
  // results outside ISSUE/DRAIN or beyond a full batch are dropped
  assign accept      = bus.mul_out_valid && ((state == S_ISSUE) || (state == S_DRAIN))
                       && (res_cnt != CNT_FULL);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (go)                        state_nxt = S_ISSUE;
      S_ISSUE:     if (issue_cnt == CNT_LAST)     state_nxt = S_DRAIN;
      S_DRAIN:     if (res_cnt == CNT_FULL)       state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.done || done_seen)     state_nxt = S_FINISH;
      S_FINISH:                                   state_nxt = S_IDLE;
      default:                                    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      issue_cnt  <= '0;
      res_cnt    <= '0;
      done_seen  <= 1'b0;
      in_valid_q <= 1'b0;
      we_q       <= 1'b0;
      c_q        <= '0;
      ov_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_valid_q <= issuing;
      we_q       <= accept;
      if (accept) begin
        c_q  <= bus.mul_result;
        ov_q <= bus.mul_overflow;
      end
      if (batch_start) begin
        issue_cnt <= '0;
        res_cnt   <= '0;
        done_seen <= 1'b0;
      end else begin
        if (issuing)              issue_cnt <= issue_cnt + CNT_W'(1);
        if (accept)               res_cnt   <= res_cnt + CNT_W'(1);
        // the stack may flag done before the last result lands; remember it
        if (collecting && bus.done) done_seen <= 1'b1;
      end
    end
  end

`ifdef FPM_SEQ_OV_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ov_count <= '0;
    end else if (batch_start) begin
      ov_count <= '0;
    end else if (accept && bus.mul_overflow) begin
      ov_count <= ov_count + CNT_W'(1);
    end
  end
`endif

  assign bus.start        = issuing;
  assign bus.mul_in_valid = in_valid_q;
  assign bus.mul_a        = bus.a;
  assign bus.mul_b        = bus.b;
  assign bus.we           = we_q;
  assign bus.we_ov        = we_q;
  assign bus.c            = c_q;
  assign bus.overflow     = ov_q;
  assign busy             = (state != S_IDLE);
  assign finished         = (state == S_FINISH);

endmodule

// File: tb/tb_fpm_batch_sequencer.sv
// Bench for fpm_batch_sequencer: stack model, core model (fpm_valid_pipe plus a
// power-of-two multiplier), and a cycle-level reference model of the batch rules.
module tb_fpm_batch_sequencer;
  import fpm_pkg::*;

  localparam int NV  = 32;
  localparam int LAT = 3;
  localparam int CW  = $clog2(NV + 1);

  logic clk = 1'b0;
  logic reset, go, core_rst_n, stray_v, pipe_v, busy, finished;
  logic done_auto, done_man;
`ifdef FPM_SEQ_OV_COUNT_EN
  logic [CW-1:0] ov_count;
`endif

  fpm_batch_sequencer_if #(.DATA_W(32)) bus ();

  always #5 clk = ~clk;

  assign bus.mul_out_valid = pipe_v | stray_v;
  assign bus.done          = done_auto | done_man;

  fpm_batch_sequencer #(.NUM_VECTORS(NV), .MUL_LATENCY(LAT), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .busy     (busy),
    .finished (finished),
`ifdef FPM_SEQ_OV_COUNT_EN
    .ov_count (ov_count),
`endif
    .bus      (bus)
  );

  fpm_valid_pipe #(.DEPTH(LAT)) u_core (
    .clk       (clk),
    .reset     (core_rst_n),
    .in_valid  (bus.mul_in_valid),
    .out_valid (pipe_v)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Multiplier for b = +/- power of two: exponent add, overflow saturates to inf.
  function automatic logic [32:0] pmul(input logic [31:0] x, input logic [31:0] y);
    int   e;
    logic s;
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    s = x[31] ^ y[31];
    if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
    return {1'b0, s, e[7:0], x[22:0]};
  endfunction

  logic [31:0] A [NV];
  logic [31:0] B [NV];

  // ---------------- stack and core models ----------------
  int          ptr;
  int          stk_we_cnt;
  int          done_timer;
  bit          auto_done;
  bit          start_seen, we_seen;
  logic [32:0] core_q [$];

  initial begin
    start_seen = 0;
    we_seen    = 0;
    forever begin
      @(negedge clk);
      start_seen = bus.start;
      we_seen    = bus.we;
      if (bus.mul_in_valid) core_q.push_back(pmul(bus.mul_a, bus.mul_b));
    end
  end

  initial begin
    bus.a = '0; bus.b = '0; bus.mul_result = '0; bus.mul_overflow = 1'b0;
    done_auto = 1'b0; ptr = 0; stk_we_cnt = 0; done_timer = 0;
    forever begin
      @(posedge clk); #1;
      if (start_seen && ptr < NV) begin
        bus.a = A[ptr];
        bus.b = B[ptr];
        ptr++;
      end
      if (we_seen) begin
        stk_we_cnt++;
        if (auto_done && stk_we_cnt == NV) done_timer = 3;
      end
      done_auto = 1'b0;
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) done_auto = 1'b1;
      end
      if (pipe_v && core_q.size() > 0) {bus.mul_overflow, bus.mul_result} = core_q.pop_front();
    end
  end

  // ---------------- reference model + compare ----------------
  bit          active, pend, exp_we, exp_start, exp_fin, idle;
  int          t_act, m_res, m_done, m_last, m_ovc;
  logic [31:0] m_c;
  logic        m_ov;
  bit          p_acc, p_mov, p_start, p_ovf;
  logic [31:0] p_res;

  int          obs_start, obs_we, obs_fin;
  int          t_first_start, t_first_we, t_last_we, t_fin;
  logic [31:0] first_c, first_mula, first_mulb;
  logic        first_ov, second_ov, second_we_ov;

  task automatic clear_obs();
    obs_start = 0; obs_we = 0; obs_fin = 0;
    t_first_start = -1; t_first_we = -1; t_last_we = -1; t_fin = -1;
    first_c = '0; first_mula = '0; first_mulb = '0;
    first_ov = 1'b0; second_ov = 1'b0; second_we_ov = 1'b0;
  endtask

  initial begin
    int t;
    t = 0;
    active = 0; pend = 0; m_res = 0; m_done = -1; m_last = 0; m_ovc = 0; t_act = 0;
    m_c = '0; m_ov = 1'b0; p_acc = 0; p_mov = 0; p_start = 0; p_ovf = 0; p_res = '0;
    forever begin
      @(negedge clk);
      t++;
      if (!reset) begin
        active = 0; pend = 0; m_res = 0; m_done = -1; m_last = 0; m_ovc = 0;
        m_c = '0; m_ov = 1'b0; p_acc = 0; p_mov = 0; p_start = 0; p_ovf = 0; p_res = '0;
        chk("rst_start", 64'(bus.start), 0);
        chk("rst_we", 64'(bus.we), 0);
        chk("rst_we_ov", 64'(bus.we_ov), 0);
        chk("rst_c", 64'(bus.c), 0);
        chk("rst_overflow", 64'(bus.overflow), 0);
        chk("rst_mul_in_valid", 64'(bus.mul_in_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_finished", 64'(finished), 0);
`ifdef FPM_SEQ_OV_COUNT_EN
        chk("rst_ov_count", 64'(ov_count), 0);
`endif
      end else begin
        if (pend) begin
          active = 1; pend = 0; t_act = t; m_res = 0; m_done = -1; m_ovc = 0;
        end
        exp_we = p_mov && p_acc;
        if (exp_we) begin
          m_res++; m_c = p_res; m_ov = p_ovf; m_last = t;
          if (p_ovf) m_ovc++;
        end
        exp_start = active && (t - t_act < NV);
        exp_fin   = active && (m_res == NV) && (t >= m_last + 2) && (m_done >= 0) && (t >= m_done + 1);

        chk("start", 64'(bus.start), 64'(exp_start));
        chk("mul_in_valid", 64'(bus.mul_in_valid), 64'(p_start));
        chk("we", 64'(bus.we), 64'(exp_we));
        chk("we_ov", 64'(bus.we_ov), 64'(exp_we));
        chk("c", 64'(bus.c), 64'(m_c));
        chk("overflow", 64'(bus.overflow), 64'(m_ov));
        chk("busy", 64'(busy), 64'(active));
        chk("finished", 64'(finished), 64'(exp_fin));
        chk("mul_a", 64'(bus.mul_a), 64'(bus.a));
        chk("mul_b", 64'(bus.mul_b), 64'(bus.b));
`ifdef FPM_SEQ_OV_COUNT_EN
        chk("ov_count", 64'(ov_count), 64'(m_ovc));
`endif

        if (bus.start) begin
          if (obs_start == 0) t_first_start = t;
          obs_start++;
        end
        if (t_first_start >= 0 && t == t_first_start + 1) begin
          first_mula = bus.mul_a;
          first_mulb = bus.mul_b;
        end
        if (bus.we) begin
          obs_we++;
          if (obs_we == 1) begin t_first_we = t; first_c = bus.c; first_ov = bus.overflow; end
          if (obs_we == 2) begin second_ov = bus.overflow; second_we_ov = bus.we_ov; end
          t_last_we = t;
        end
        if (finished) begin obs_fin++; t_fin = t; end

        if (active && bus.done && m_done < 0) m_done = t;
        idle    = !active;
        p_acc   = active && !exp_fin && (m_res < NV);
        p_mov   = bus.mul_out_valid;
        p_res   = bus.mul_result;
        p_ovf   = bus.mul_overflow;
        p_start = exp_start;
        if (exp_fin) active = 0;
        if (idle && go) pend = 1;
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic go_pulse();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic start_batch();
    ptr = 0;
    stk_we_cnt = 0;
    clear_obs();
    go_pulse();
  endtask

  task automatic wait_fin(input string nm);
    for (int i = 0; i < 300 && obs_fin == 0; i++) @(posedge clk);
    #1;
    chk(nm, 64'(obs_fin != 0), 1);
  endtask

  task automatic wait_start_low(input string nm);
    for (int i = 0; i < 100 && (bus.start || obs_start == 0); i++) begin
      @(posedge clk); #1;
    end
    chk(nm, 64'(bus.start), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; go = 1'b0; core_rst_n = 1'b0; stray_v = 1'b0; done_man = 1'b0; auto_done = 1;
    clear_obs();
    A[0] = 32'h3F80_0000; B[0] = 32'h4000_0000;
    A[1] = 32'h7F7F_FFFF; B[1] = 32'h4000_0000;
    for (int k = 2; k < NV; k++) begin
      A[k] = 32'h3FC0_0000 + 32'(k << 12);
      B[k] = {(k % 3 == 2), 8'(124 + k % 6), 23'h0};
    end

    repeat (3) @(posedge clk);
    #3;
    chk("rst_hold_busy", 64'(busy), 0);
    core_rst_n = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // tests 1-3: full batch, first pair values, overflow pair
    start_batch();
    wait_fin("t1_finish_timeout");
    repeat (5) @(posedge clk);
    #1;
    chk("t1_start_count", 64'(obs_start), 32);
    chk("t1_we_count", 64'(obs_we), 32);
    chk("t1_first_we_latency", 64'(t_first_we - t_first_start), 5);
    chk("t1_finished_count", 64'(obs_fin), 1);
    chk("t1_finish_after_last_we", 64'(t_fin - t_last_we), 4);
    chk("t2_mul_a", 64'(first_mula), 64'h3F80_0000);
    chk("t2_mul_b", 64'(first_mulb), 64'h4000_0000);
    chk("t2_c", 64'(first_c), 64'h4000_0000);
    chk("t2_overflow", 64'(first_ov), 0);
    chk("t3_overflow", 64'(second_ov), 1);
    chk("t3_we_ov", 64'(second_we_ov), 1);
`ifdef FPM_SEQ_OV_COUNT_EN
    chk("t3_ov_count", 64'(ov_count), 1);
`endif

    // test 4: go during ISSUE and DRAIN is ignored
    start_batch();
    repeat (8) @(posedge clk);
    go_pulse();
    wait_start_low("t4_issue_end_timeout");
    go_pulse();
    wait_fin("t4_finish_timeout");
    repeat (20) @(posedge clk);
    #1;
    chk("t4_start_count", 64'(obs_start), 32);
    chk("t4_finished_count", 64'(obs_fin), 1);
    chk("t4_busy_after", 64'(busy), 0);

    // test 5: reset in ISSUE cycle 10, then a clean batch
    start_batch();
    repeat (9) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t5_start_drop", 64'(bus.start), 0);
    chk("t5_we_drop", 64'(bus.we), 0);
    chk("t5_busy_drop", 64'(busy), 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    repeat (10) @(posedge clk);
    start_batch();
    wait_fin("t5_finish_timeout");
    #1;
    chk("t5_start_count", 64'(obs_start), 32);
    chk("t5_we_count", 64'(obs_we), 32);

    // test 6: stray core valid in IDLE, early done in DRAIN
    repeat (5) @(posedge clk);
    clear_obs();
    @(posedge clk); #1 stray_v = 1'b1;
    @(posedge clk); #1 stray_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_stray_we", 64'(obs_we), 0);
    auto_done = 0;
    start_batch();
    wait_start_low("t6_issue_end_timeout");
    @(posedge clk); #1 done_man = 1'b1;
    @(posedge clk); #1 done_man = 1'b0;
    chk("t6_done_before_last_we", 64'(obs_we < NV), 1);
    wait_fin("t6_finish_timeout");
    #1;
    chk("t6_we_count", 64'(obs_we), 32);
    chk("t6_finish_after_last_we", 64'(t_fin - t_last_we), 2);
    auto_done = 1;
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
